multi_tick_gen: RTL and testbench
=================================

MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 Parameter NUM_CH, 4, number of independent tick channels (1..8).
REQ-002 Parameter CNT_W, 27, counter and divisor width in bits.
REQ-003 Parameter DEFAULT_DIV, 100_000_000, per-channel divisor loaded at reset.
REQ-004 clkIn  input  1  single system clock, 100 MHz; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  single-cycle strobe; writes load_div into the channel selected by load_ch.
REQ-007 load_ch  input  $clog2(NUM_CH) (min 1)  target channel index for load.
REQ-008 load_div  input  CNT_W  new divisor value.
REQ-009 enable  input  NUM_CH  per-channel count enable; a 0 freezes that channel's counter.
REQ-010 restart  input  NUM_CH  per-channel synchronous counter clear, one-cycle strobe.
REQ-011 tick  output  NUM_CH  per-channel one-clkIn-cycle pulse at terminal count.
REQ-012 square  output  NUM_CH  per-channel square wave, toggles on every tick.

Function
REQ-013 Each channel SHALL hold a count register, an active divisor and a shadow divisor, all CNT_W bits.
REQ-014 When enabled, count SHALL increment by 1 per clkIn; when count == active_div-1, count SHALL wrap to 0 and tick SHALL be 1 in the following cycle only.
REQ-015 Tick period SHALL be exactly active_div clkIn cycles; square period SHALL be 2*active_div cycles with 50% duty.
REQ-016 A divisor of 0 or 1 SHALL be treated as 1: tick held high every cycle, square toggling every cycle.
REQ-017 load SHALL write the shadow divisor of channel load_ch only; load_ch >= NUM_CH SHALL be ignored.
REQ-018 The shadow divisor SHALL transfer to the active divisor only at a wrap or at restart, so no period is ever truncated or stretched mid-cycle.
REQ-019 load and wrap in the same cycle on one channel: the wrap SHALL use the old active divisor and the new value SHALL take effect at the next wrap.
REQ-020 restart SHALL clear count to 0, copy shadow to active, and suppress tick that cycle; restart takes priority over wrap and enable.
REQ-021 With enable low, count, tick (0) and square SHALL hold; re-enabling SHALL resume from the frozen count.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-023 On reset low, every count SHALL be 0, active and shadow divisors DEFAULT_DIV, tick 0, square 0, immediately and asynchronously.
REQ-024 Reset deassertion mid-operation SHALL restart all channels from count 0 with DEFAULT_DIV; first tick DEFAULT_DIV cycles after the first enabled edge.

Configuration
REQ-025 Macro MULTI_TICK_CASCADE_EN defined: channel k>0 SHALL advance only in cycles where tick[k-1] is 1 (and enable[k] is 1), forming a prescaler chain (e.g. 1 Hz -> 1/60 Hz).
REQ-026 Macro MULTI_TICK_CASCADE_EN undefined: every channel SHALL advance on every enabled clkIn cycle; no cascade logic SHALL be present.

Structure
REQ-027 Package multi_tick_pkg SHALL hold NUM_CH, CNT_W and DEFAULT_DIV defaults and the channel-index width function.
REQ-028 One sub-module, tick_channel, SHALL implement a single counter/divisor/shadow/tick/square slice, instantiated NUM_CH times via generate.

Verification
REQ-029 Reset, DEFAULT_DIV=10, enable=all -> tick[0] first at cycle 10, then every 10 cycles; square[0] period 20.
REQ-030 load ch1 with 4 while ch1 at count 6 of div 10 -> ch1 completes 10-cycle period, then ticks every 4.
REQ-031 load_div=0 on ch2, then restart[2] -> tick[2] high every cycle, square[2] toggles every cycle.
REQ-032 enable[3] low for 7 cycles at count 3 -> no tick[3]; next tick delayed exactly 7 cycles.
REQ-033 restart[0] asserted in the wrap cycle -> no tick[0] that cycle, count 0, next tick after full period.
REQ-034 MULTI_TICK_CASCADE_EN, div ch0=5, ch1=3 -> tick[1] every 15 cycles, coincident with tick[0]'s following cycle behaviour as specified in REQ-014.

Source files
------------

// File: rtl/multi_tick_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
// Holds channel count, counter width, reset divisor and index-width function.
package multi_tick_pkg;

  localparam int          NUM_CH_DEF      = 4;
  localparam int          CNT_W_DEF       = 27;
  localparam int unsigned DEFAULT_DIV_DEF = 100_000_000;

  // Width of a channel index; never below one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, active and shadow divisor, tick and square.
// Ports: clk, rst_n, adv, restart, load, load_div -> tick, square.
module tick_channel #(
  parameter int               CNT_W   = 27,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             square
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;
  logic [CNT_W-1:0] last;
  logic             wrap;

  always_comb begin
    // Divisors 0 and 1 both mean "wrap every advance".
    last = (active_q <= CNT_W'(1)) ? '0 : active_q - CNT_W'(1);
    wrap = adv && (count_q == last);

    count_d  = count_q;
    active_d = active_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    square_d = square_q;

    if (load) shadow_d = load_div;

    // Active divisor only changes when count restarts at 0, so a
    // running period is never cut short; a load coinciding with a
    // wrap lands in shadow and waits for the following wrap.
    if (restart) begin
      count_d  = '0;
      active_d = shadow_q;
    end else if (wrap) begin
      count_d  = '0;
      active_d = shadow_q;
      tick_d   = 1'b1;
      square_d = ~square_q;
    end else if (adv) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      active_q <= RST_DIV;
      shadow_q <= RST_DIV;
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick   = tick_q;
  assign square = square_q;

endmodule

// File: rtl/multi_tick_gen.sv
// NUM_CH independent programmable tick/square generators on one clock.
// Ports: clkIn, reset(n), load/load_ch/load_div, enable, restart -> tick, square.
// Define MULTI_TICK_CASCADE_EN to chain channel k behind tick[k-1].
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter int          NUM_CH      = NUM_CH_DEF,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                          clkIn,
  input  logic                          reset,
  input  logic                          load,
  input  logic [ch_idx_w(NUM_CH)-1:0]   load_ch,
  input  logic [CNT_W-1:0]              load_div,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [NUM_CH-1:0]             restart,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             square
);

  logic [NUM_CH-1:0] adv;
  logic [NUM_CH-1:0] sel;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Out-of-range indices match no channel and are dropped.
    assign sel[k] = load && (int'(load_ch) == k);

`ifdef MULTI_TICK_CASCADE_EN
    if (k == 0) begin : g_head
      assign adv[k] = enable[k];
    end else begin : g_link
      assign adv[k] = enable[k] & tick[k-1];
    end
`else
    assign adv[k] = enable[k];
`endif

    tick_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk      (clkIn),
      .rst_n    (reset),
      .adv      (adv[k]),
      .restart  (restart[k]),
      .load     (sel[k]),
      .load_div (load_div),
      .tick     (tick[k]),
      .square   (square[k])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen with DEFAULT_DIV=10, four channels.
// Table-driven free-run check plus hand-written corner sequences.
module tb_multi_tick_gen;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [1:0] load_ch;
  logic [7:0] load_div;
  logic [3:0] enable;
  logic [3:0] restart;
  logic [3:0] tick;
  logic [3:0] square;

  int n_cmp;
  int n_err;
  int cyc;

`ifdef MULTI_TICK_CASCADE_EN
  localparam logic [3:0] MASK = 4'b0001;
  localparam bit CASC = 1'b1;
`else
  localparam logic [3:0] MASK = 4'b1111;
  localparam bit CASC = 1'b0;
`endif

  multi_tick_gen #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEFAULT_DIV (10)
  ) dut (
    .clkIn    (clk),
    .reset    (rst_n),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .enable   (enable),
    .restart  (restart),
    .tick     (tick),
    .square   (square)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [3:0] tk;
    logic [3:0] sq;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    load    = 1'b0;
    restart = '0;
    enable  = '0;
    #1;
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_square", 32'(square), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 4'hF;
    cyc    = 0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_ch  = '0;
    load_div = '0;
    enable   = '0;
    restart  = '0;

    vecs[0] = '{1,  4'hF, 4'h0, 4'h0};
    vecs[1] = '{9,  4'hF, 4'h0, 4'h0};
    vecs[2] = '{10, 4'hF, 4'hF, 4'hF};
    vecs[3] = '{11, 4'hF, 4'h0, 4'hF};
    vecs[4] = '{19, 4'hF, 4'h0, 4'hF};
    vecs[5] = '{20, 4'hF, 4'hF, 4'h0};
    vecs[6] = '{21, 4'hF, 4'h0, 4'h0};
    vecs[7] = '{29, 4'hF, 4'h0, 4'h0};
    vecs[8] = '{30, 4'hF, 4'hF, 4'hF};
    vecs[9] = '{35, 4'hF, 4'h0, 4'hF};

    // Free run at the reset divisor.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en;
      while (cyc < vecs[i].cyc) step();
      chk("tbl_tick", 32'(tick & MASK), 32'(vecs[i].tk & MASK));
      chk("tbl_square", 32'(square & MASK), 32'(vecs[i].sq & MASK));
    end

    // Reset lands mid-period with square high: must clear at once.
    do_reset();

`ifndef MULTI_TICK_CASCADE_EN
    // Shadow load at count 6: current 10-cycle period completes.
    for (int c = 1; c <= 22; c++) begin
      step();
      chk("shadow_t1", 32'(tick[1]),
          32'(c == 10 || c == 14 || c == 18 || c == 22));
      chk("shadow_t0", 32'(tick[0]), 32'(c == 10 || c == 20));
      load = 1'b0;
      if (c == 6) begin
        load     = 1'b1;
        load_ch  = 2'd1;
        load_div = 8'd4;
      end
    end

    // Divisor 0 behaves as 1 after restart.
    do_reset();
    load     = 1'b1;
    load_ch  = 2'd2;
    load_div = 8'd0;
    step();
    load    = 1'b0;
    restart = 4'b0100;
    chk("d0_pre", 32'(tick[2]), 32'h0);
    step();
    restart = '0;
    chk("d0_rst", 32'(tick[2]), 32'h0);
    for (int c = 3; c <= 8; c++) begin
      step();
      chk("d0_tick", 32'(tick[2]), 32'h1);
      chk("d0_square", 32'(square[2]), 32'(c % 2));
    end

    // Freeze channel 3 for seven edges at count 3.
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("frz_t3", 32'(tick[3]), 32'(c == 17));
      chk("frz_s3", 32'(square[3]), 32'(c == 17));
      chk("frz_t0", 32'(tick[0]), 32'(c == 10));
      if (c == 3) enable[3] = 1'b0;
      if (c == 10) enable[3] = 1'b1;
    end
`endif

    // Restart in the wrap cycle suppresses that tick.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("rw_t0", 32'(tick[0]), 32'(c == 20));
      chk("rw_s0", 32'(square[0]), 32'(c == 20));
      if (!CASC) chk("rw_t1", 32'(tick[1]), 32'(c == 10 || c == 20));
      restart = '0;
      if (c == 9) restart = 4'b0001;
    end

    // ch0 div 5, ch1 div 3, both restarted at edge 3.
    do_reset();
    load     = 1'b1;
    load_ch  = 2'd0;
    load_div = 8'd5;
    step();
    load_ch  = 2'd1;
    load_div = 8'd3;
    step();
    load    = 1'b0;
    restart = 4'b0011;
    step();
    restart = '0;
    for (int c = 4; c <= 35; c++) begin
      step();
      chk("cas_t0", 32'(tick[0]), 32'((c - 3) % 5 == 0));
      if (CASC)
        chk("cas_t1", 32'(tick[1]), 32'(c == 19 || c == 34));
      else
        chk("cas_t1", 32'(tick[1]), 32'((c - 3) % 3 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
